// File: rtl/nvdla_csb_pkg.sv
// rtl/nvdla_csb_pkg.sv - shared types and constants for the CSB initiator
package nvdla_csb_pkg;

    localparam int CSB_DW = 32;

    localparam logic [CSB_DW-1:0] CSB_ERR_DATA = 32'hBADC_5B00;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CSB_REQ  = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RESP     = 2'd3
    } csb_mst_state_e;

endpackage

// File: rtl/nvdla_csb_master_if.sv
// rtl/nvdla_csb_master_if.sv - CSB request/response signal bundle
interface nvdla_csb_intf #(
    parameter int CSB_AW = 16
);
    import nvdla_csb_pkg::*;

    logic              valid;
    logic              ready;
    logic [CSB_AW-1:0] addr;
    logic [CSB_DW-1:0] wdat;
    logic              write;
    logic              nposted;
    logic              r_valid;
    logic [CSB_DW-1:0] r_data;
    logic              wr_complete;

    modport master (
        output valid, addr, wdat, write, nposted,
        input  ready, r_valid, r_data, wr_complete
    );

    modport slave (
        input  valid, addr, wdat, write, nposted,
        output ready, r_valid, r_data, wr_complete
    );

endinterface

// File: rtl/nvdla_csb_master_timeout.sv
// rtl/nvdla_csb_master_timeout.sv - loadable response-timeout counter
module nvdla_csb_timeout #(
    parameter int LIMIT = 1024,
    localparam int CW   = $clog2(LIMIT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] count;

    // Clear has priority so a fresh handshake always restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/nvdla_csb_master.sv
// rtl/nvdla_csb_master.sv - peripheral bus to NVDLA CSB single-outstanding bridge
module nvdla_csb_master
    import nvdla_csb_pkg::*;
#(
    parameter int   CSB_AW         = 16,
    parameter logic NPOSTED_WR     = 1'b1,
    parameter int   TIMEOUT_CYCLES = 1024
) (
    input  logic        csb_clk,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o,
    output logic        spurious_o,
    nvdla_csb_intf.master csb
);

    csb_mst_state_e state;
    logic           wen_q;
    logic           chk_err;
    logic           to_clr;
    logic           to_en;
    logic           to_expired;
    logic           rsp_read;
    logic           rsp_write;
    logic           spurious_evt;

    assign gnt_o = req_i && (state == ST_IDLE);

    // Accesses the CSB cannot express are rejected before touching the bus.
    assign chk_err = (add_i[1:0] != 2'b00)
                  || ((add_i >> (CSB_AW + 2)) != 32'd0)
                  || (!wen_i && (be_i != 4'hF));

    assign to_clr = (state == ST_CSB_REQ) && csb.ready;
    assign to_en  = (state == ST_WAIT_RSP);

    assign rsp_read  = wen_q && csb.r_valid;
    assign rsp_write = !wen_q && csb.wr_complete;

    // A response counts as spurious unless it is the one kind we are waiting for.
    assign spurious_evt = (state != ST_WAIT_RSP) ? (csb.r_valid || csb.wr_complete)
                                                 : (wen_q ? csb.wr_complete : csb.r_valid);

    nvdla_csb_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (csb_clk),
        .rst      (rst_i),
        .clr      (to_clr),
        .en       (to_en),
        .load     (1'b0),
        .load_val ('0),
        .expired  (to_expired)
    );

    // Transaction FSM with all bus-facing outputs registered.
    always_ff @(posedge csb_clk or posedge rst_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            wen_q       <= 1'b0;
            r_valid_o   <= 1'b0;
            r_rdata_o   <= '0;
            r_opc_o     <= 1'b0;
            spurious_o  <= 1'b0;
            csb.valid   <= 1'b0;
            csb.addr    <= '0;
            csb.wdat    <= '0;
            csb.write   <= 1'b0;
            csb.nposted <= 1'b0;
        end else begin
            r_valid_o <= 1'b0;
            r_rdata_o <= '0;
            r_opc_o   <= 1'b0;

            if (spurious_evt) begin
                spurious_o <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (req_i) begin
                        wen_q <= wen_i;
                        if (chk_err) begin
                            state     <= ST_RESP;
                            r_valid_o <= 1'b1;
                            r_opc_o   <= 1'b1;
                            r_rdata_o <= CSB_ERR_DATA;
                        end else begin
                            state       <= ST_CSB_REQ;
                            csb.valid   <= 1'b1;
                            csb.addr    <= add_i[CSB_AW+1:2];
                            csb.wdat    <= data_i;
                            csb.write   <= ~wen_i;
                            csb.nposted <= wen_i ? 1'b0 : NPOSTED_WR;
                        end
                    end
                end

                ST_CSB_REQ: begin
                    if (csb.ready) begin
                        csb.valid <= 1'b0;
                        if (wen_q || csb.nposted) begin
                            state <= ST_WAIT_RSP;
                        end else begin
                            state     <= ST_RESP;
                            r_valid_o <= 1'b1;
                        end
                    end
                end

                ST_WAIT_RSP: begin
                    if (rsp_read) begin
                        state     <= ST_RESP;
                        r_valid_o <= 1'b1;
                        r_rdata_o <= csb.r_data;
                    end else if (rsp_write) begin
                        state     <= ST_RESP;
                        r_valid_o <= 1'b1;
                    end else if (to_expired) begin
                        state     <= ST_RESP;
                        r_valid_o <= 1'b1;
                        r_opc_o   <= 1'b1;
                        r_rdata_o <= CSB_ERR_DATA;
                    end
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nvdla_csb_master.sv
// tb/tb_nvdla_csb_master.sv - directed self-checking bench for nvdla_csb_master
module tb_nvdla_csb_master;

    logic        clk;
    logic        rst;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
    logic        spurious;

    int tests;
    int fails;

    nvdla_csb_intf #(.CSB_AW(16)) csb_if ();

    nvdla_csb_master #(
        .CSB_AW         (16),
        .NPOSTED_WR     (1'b1),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .csb_clk    (clk),
        .rst_i      (rst),
        .req_i      (req),
        .gnt_o      (gnt),
        .add_i      (add),
        .wen_i      (wen),
        .be_i       (be),
        .data_i     (wdata),
        .r_valid_o  (r_valid),
        .r_rdata_o  (r_rdata),
        .r_opc_o    (r_opc),
        .spurious_o (spurious),
        .csb        (csb_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic start_req(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        req   = 1'b1;
        add   = a;
        wen   = w;
        be    = b;
        wdata = d;
        #1;
        chk("gnt_idle", {31'd0, gnt}, 32'd1);
    endtask

    initial begin
        logic early;
        tests = 0;
        fails = 0;
        rst = 1'b1;
        req = 1'b0; add = '0; wen = 1'b0; be = '0; wdata = '0;
        csb_if.ready = 1'b0; csb_if.r_valid = 1'b0; csb_if.r_data = '0; csb_if.wr_complete = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();

        // Reset state
        chk("rst_gnt", {31'd0, gnt}, 32'd0);
        chk("rst_rvalid", {31'd0, r_valid}, 32'd0);
        chk("rst_rdata", r_rdata, 32'd0);
        chk("rst_opc", {31'd0, r_opc}, 32'd0);
        chk("rst_spurious", {31'd0, spurious}, 32'd0);
        chk("rst_csb_valid", {31'd0, csb_if.valid}, 32'd0);
        chk("rst_csb_addr", {16'd0, csb_if.addr}, 32'd0);

        // Read: ready immediately, r_valid one cycle later
        start_req(32'h0000_1004, 1'b1, 4'hF, 32'd0);
        cyc();                                            // T+1
        #1;
        chk("rd_gnt_busy", {31'd0, gnt}, 32'd0);
        req = 1'b0;
        chk("rd_csb_valid", {31'd0, csb_if.valid}, 32'd1);
        chk("rd_csb_addr", {16'd0, csb_if.addr}, 32'h0401);
        chk("rd_csb_write", {31'd0, csb_if.write}, 32'd0);
        chk("rd_csb_nposted", {31'd0, csb_if.nposted}, 32'd0);
        csb_if.ready = 1'b1;
        cyc();                                            // T+2
        csb_if.ready = 1'b0;
        chk("rd_csb_valid_drop", {31'd0, csb_if.valid}, 32'd0);
        chk("rd_rvalid_early", {31'd0, r_valid}, 32'd0);
        csb_if.r_valid = 1'b1; csb_if.r_data = 32'hCAFE_0001;
        cyc();                                            // T+3
        csb_if.r_valid = 1'b0;
        chk("rd_rvalid", {31'd0, r_valid}, 32'd1);
        chk("rd_rdata", r_rdata, 32'hCAFE_0001);
        chk("rd_opc", {31'd0, r_opc}, 32'd0);
        cyc();
        chk("rd_rvalid_pulse", {31'd0, r_valid}, 32'd0);
        chk("rd_spurious", {31'd0, spurious}, 32'd0);

        // Non-posted write with ready delayed three cycles
        start_req(32'h0000_0008, 1'b0, 4'hF, 32'h1234_5678);
        cyc();
        req = 1'b0;
        chk("wr_csb_valid", {31'd0, csb_if.valid}, 32'd1);
        chk("wr_csb_write", {31'd0, csb_if.write}, 32'd1);
        chk("wr_csb_nposted", {31'd0, csb_if.nposted}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("wr_hold_valid", {31'd0, csb_if.valid}, 32'd1);
            chk("wr_hold_addr", {16'd0, csb_if.addr}, 32'h0002);
            chk("wr_hold_wdat", csb_if.wdat, 32'h1234_5678);
        end
        csb_if.ready = 1'b1;
        cyc();
        csb_if.ready = 1'b0;
        chk("wr_valid_drop", {31'd0, csb_if.valid}, 32'd0);
        csb_if.wr_complete = 1'b1;
        cyc();
        csb_if.wr_complete = 1'b0;
        chk("wr_rvalid", {31'd0, r_valid}, 32'd1);
        chk("wr_opc", {31'd0, r_opc}, 32'd0);
        chk("wr_rdata", r_rdata, 32'd0);
        cyc();

        // Protocol check errors: partial-strobe write, out of window, misaligned
        start_req(32'h0000_0010, 1'b0, 4'h3, 32'h1111_1111);
        cyc();
        req = 1'b0;
        chk("be_rvalid", {31'd0, r_valid}, 32'd1);
        chk("be_opc", {31'd0, r_opc}, 32'd1);
        chk("be_rdata", r_rdata, 32'hBADC_5B00);
        chk("be_csb_valid", {31'd0, csb_if.valid}, 32'd0);
        cyc();
        chk("be_csb_valid2", {31'd0, csb_if.valid}, 32'd0);

        start_req(32'h0004_0000, 1'b1, 4'hF, 32'd0);
        cyc();
        req = 1'b0;
        chk("oow_rvalid", {31'd0, r_valid}, 32'd1);
        chk("oow_opc", {31'd0, r_opc}, 32'd1);
        chk("oow_rdata", r_rdata, 32'hBADC_5B00);
        chk("oow_csb_valid", {31'd0, csb_if.valid}, 32'd0);
        cyc();

        start_req(32'h0000_0002, 1'b1, 4'hF, 32'd0);
        cyc();
        req = 1'b0;
        chk("mis_rvalid", {31'd0, r_valid}, 32'd1);
        chk("mis_opc", {31'd0, r_opc}, 32'd1);
        chk("mis_rdata", r_rdata, 32'hBADC_5B00);
        chk("mis_csb_valid", {31'd0, csb_if.valid}, 32'd0);
        cyc();

        // Timeout: handshake at H, error response at H+9, late r_valid at H+12
        start_req(32'h0000_0010, 1'b1, 4'hF, 32'd0);
        cyc();
        req = 1'b0;
        csb_if.ready = 1'b1;                              // H
        cyc();                                            // H+1
        csb_if.ready = 1'b0;
        early = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            early = early | r_valid;
            cyc();
        end                                               // H+9
        chk("to_no_early", {31'd0, early}, 32'd0);
        chk("to_rvalid", {31'd0, r_valid}, 32'd1);
        chk("to_opc", {31'd0, r_opc}, 32'd1);
        chk("to_rdata", r_rdata, 32'hBADC_5B00);
        cyc(); cyc(); cyc();                              // H+12
        chk("to_spurious_before", {31'd0, spurious}, 32'd0);
        csb_if.r_valid = 1'b1; csb_if.r_data = 32'hDEAD_0000;
        cyc();
        csb_if.r_valid = 1'b0;
        chk("to_spurious_late", {31'd0, spurious}, 32'd1);
        chk("to_late_no_rsp", {31'd0, r_valid}, 32'd0);

        // Completion on the expiry cycle wins over the timeout
        start_req(32'h0000_0020, 1'b1, 4'hF, 32'd0);
        cyc();
        req = 1'b0;
        csb_if.ready = 1'b1;                              // H
        cyc();
        csb_if.ready = 1'b0;
        for (int k = 0; k < 7; k++) cyc();                // H+8
        csb_if.r_valid = 1'b1; csb_if.r_data = 32'h5A5A_0008;
        cyc();
        csb_if.r_valid = 1'b0;
        chk("race_rvalid", {31'd0, r_valid}, 32'd1);
        chk("race_opc", {31'd0, r_opc}, 32'd0);
        chk("race_rdata", r_rdata, 32'h5A5A_0008);
        cyc();

        // Reset during WAIT_RSP aborts with no response
        start_req(32'h0000_0030, 1'b1, 4'hF, 32'd0);
        cyc();
        req = 1'b0;
        csb_if.ready = 1'b1;
        cyc();
        csb_if.ready = 1'b0;
        cyc();
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_spurious", {31'd0, spurious}, 32'd0);
        chk("mid_rst_csb_addr", {16'd0, csb_if.addr}, 32'd0);
        chk("mid_rst_csb_valid", {31'd0, csb_if.valid}, 32'd0);
        chk("mid_rst_rvalid", {31'd0, r_valid}, 32'd0);
        cyc();
        rst = 1'b0;
        early = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            early = early | r_valid;
        end
        chk("post_rst_no_rsp", {31'd0, early}, 32'd0);

        start_req(32'h0000_1004, 1'b1, 4'hF, 32'd0);
        cyc();
        req = 1'b0;
        chk("post_rst_csb_addr", {16'd0, csb_if.addr}, 32'h0401);
        csb_if.ready = 1'b1;
        cyc();
        csb_if.ready = 1'b0;
        csb_if.r_valid = 1'b1; csb_if.r_data = 32'h0BAD_F00D;
        cyc();
        csb_if.r_valid = 1'b0;
        chk("post_rst_rdata", r_rdata, 32'h0BAD_F00D);
        chk("post_rst_rvalid", {31'd0, r_valid}, 32'd1);
        cyc();
        csb_if.wr_complete = 1'b1;
        cyc();
        csb_if.wr_complete = 1'b0;
        chk("idle_spurious", {31'd0, spurious}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nvdla_csb_master.md
# nvdla_csb_master

Single-outstanding bridge from the cluster's peripheral request bus onto the NVDLA CSB (configuration space bus), acting as the CSB initiator. The peripheral bus carries byte addresses and byte enables. The block translates each access into one CSB transaction, waits for the CSB read data or write completion, and returns one peripheral response. It sits between the peripheral interconnect and the accelerator's CSB slave port. It adds protocol checks and a response timeout so a hung accelerator cannot stall the host.

## Interface
Parameters:
- CSB_AW, 16, CSB word-address width; peripheral window is 2^(CSB_AW+2) bytes.
- NPOSTED_WR, 1'b1, value driven on csb.nposted for writes (1 = wait for wr_complete).
- TIMEOUT_CYCLES, 1024, response timeout measured from CSB handshake; must be ≥ 2.

Ports:
- csb_clk  in  1  single clock for the whole block.
- rst_i  in  1  reset, asynchronous, active-high.
- req_i  in  1  peripheral request.
- gnt_o  out  1  request accepted.
- add_i  in  32  byte address.
- wen_i  in  1  1 = read, 0 = write.
- be_i  in  4  byte enables.
- data_i  in  32  write data.
- r_valid_o  out  1  response valid, one-cycle pulse.
- r_rdata_o  out  32  read data, or error code.
- r_opc_o  out  1  1 = error response.
- spurious_o  out  1  sticky flag; cleared only by reset.
- csb  modport master  nvdla_csb_intf:
  - outputs valid, addr[CSB_AW-1:0], wdat[31:0], write, nposted.
  - inputs ready, r_valid, r_data[31:0], wr_complete.

## Operation
- FSM states:
  - IDLE, CSB_REQ, WAIT_RSP, RESP.
- IDLE:
  - gnt_o = req_i, combinationally.
  - On req_i, register add_i, wen_i, be_i and data_i.
  - Run the checks below; go to RESP with error on any failure, otherwise go to CSB_REQ.
- Checks:
  - add_i[1:0] != 0 → error.
  - add_i[31:CSB_AW+2] != 0 → error.
  - A write with be_i != 4'hF → error; CSB has no strobes.
- CSB_REQ:
  - csb.valid = 1.
  - csb.addr = add[CSB_AW+1:2], csb.wdat = data, csb.write = ~wen.
  - csb.nposted = write ? NPOSTED_WR : 0.
  - All CSB outputs are held stable until csb.ready.
  - On handshake: if this is a read, or a write with nposted, go to WAIT_RSP and clear the timeout counter. A posted write goes to RESP with success.
- WAIT_RSP:
  - A read completes on csb.r_valid; capture csb.r_data.
  - A nposted write completes on csb.wr_complete; rdata = 0.
  - Either completion goes to RESP with success.
  - The counter increments every cycle. When it reaches TIMEOUT_CYCLES-1 with no completion, go to RESP with error.
- RESP:
  - r_valid_o = 1 for exactly one cycle, then return to IDLE.
  - The peripheral bus has no response backpressure.
- Error responses: r_opc_o = 1, r_rdata_o = 32'hBADC_5B00.
- Success responses: r_opc_o = 0.
- Spurious events: csb.r_valid or csb.wr_complete in any state other than WAIT_RSP sets spurious_o.
  - A read also sets it if wr_complete arrives; a write also sets it if r_valid arrives.
  - Spurious data is discarded.
- Simultaneous completion and timeout expiry in the same cycle: completion wins.

## Timing
- Reset values:
  - State IDLE.
  - gnt_o follows req_i combinationally, so it is 0 whenever req_i = 0.
  - r_valid_o = 0, r_rdata_o = 0, r_opc_o = 0.
  - spurious_o = 0.
  - csb.valid = 0, csb.addr = 0, csb.wdat = 0, csb.write = 0, csb.nposted = 0.
  - Counter = 0.
- Reset asserted mid-transaction aborts immediately; no response is produced. A CSB response arriving after reset release sets spurious_o.
- All outputs except gnt_o are registered.
- Latency, with grant at cycle T:
  - csb.valid rises at T+1.
  - With ready at T+1 and r_valid at T+2: r_valid_o at T+3.
  - Posted write with ready at T+1: r_valid_o at T+2.
  - Check error: r_valid_o at T+1.
  - Timeout, CSB handshake at H: r_valid_o at H+TIMEOUT_CYCLES+1.
- Throughput: at most one outstanding access; gnt_o is 0 outside IDLE.

## Structure
- Shared package nvdla_csb_pkg holds:
  - the state enum csb_mst_state_e;
  - the constant CSB_ERR_DATA = 32'hBADC_5B00;
  - the CSB data width of 32.
- Optional sub-module nvdla_csb_timeout: a loadable counter with clear, enable and an expired flag, reusable on the DBB side.
- Everything else stays flat in this module.

## Test plan
- Read: add_i=0x0000_1004, ready at once, r_valid with r_data=0xCAFE_0001 two cycles later → csb.addr=0x0401, csb.write=0; r_valid_o at T+3 with rdata=0xCAFE_0001, opc=0.
- Nposted write: add_i=0x8, data_i=0x1234_5678, be_i=0xF, ready delayed 3 cycles, then wr_complete → csb.valid held with stable addr=0x2 and wdat; r_valid_o one cycle after wr_complete, opc=0.
- Protocol errors:
  - be_i=0x3 write → r_valid_o at T+1, opc=1, rdata=0xBADC_5B00, csb.valid never asserted.
  - add_i=0x0004_0000 (CSB_AW=16) → same error response.
  - add_i=0x2 → same error response.
- Timeout: TIMEOUT_CYCLES=8, read accepted at H, no response → error response at H+9. A late r_valid at H+12 sets spurious_o.
- Completion and timeout in the same cycle → success with the captured data.
- Reset mid-op: assert rst_i during WAIT_RSP → all outputs return to reset values asynchronously, next req_i granted normally.
